// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA region writer and its word unpacker.
package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_EMIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [16:0] BG_BASE = 17'h057E4;
    localparam logic [16:0] BG_LAST = 17'h0AFC8;

    function automatic int lanes_of(input int data_w, input int pixel_w);
        return data_w / pixel_w;
    endfunction

    function automatic int lane_w_of(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/vga_word_unpacker.sv
// Holds one packed pixel word and a lane pointer; exposes the current lane's colour.
module vga_word_unpacker
    import vga_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int PIXEL_W = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               load,
    input  logic               advance,
    input  logic [DATA_W-1:0]  in_data,
    output logic [PIXEL_W-1:0] colour,
    output logic               last_lane
);

    localparam int LANES  = lanes_of(DATA_W, PIXEL_W);
    localparam int LANE_W = lane_w_of(LANES);

    logic [DATA_W-1:0] word_r;
    logic [LANE_W-1:0] lane_r;

    assign last_lane = (lane_r == LANE_W'(LANES - 1));

    // Word and lane registers: load restarts at lane 0, advance steps one lane.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            word_r <= '0;
            lane_r <= '0;
        end else if (load) begin
            word_r <= in_data;
            lane_r <= '0;
        end else if (advance) begin
            lane_r <= last_lane ? '0 : lane_r + LANE_W'(1);
        end else begin
            lane_r <= lane_r;
        end
    end

    // Lane multiplexer.
    always_comb begin
        colour = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_r == LANE_W'(i)) begin
                colour = word_r[i*PIXEL_W +: PIXEL_W];
            end else begin
                colour = colour;
            end
        end
    end

endmodule

// File: rtl/vga_region_writer.sv
// Streams packed pixel words into a linear framebuffer window, one plot per cycle.
// Optional build macro VGA_REGION_WRAP_EN: the window restarts at its base instead of finishing.
module vga_region_writer
    import vga_pkg::*;
#(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 32,
    parameter int PIXEL_W = 8
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  cfg_base,
    input  logic [ADDR_W-1:0]  cfg_last,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               pix_plot,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic [PIXEL_W-1:0] pix_colour,
    output logic               busy,
    output logic               done,
    output logic               wrap_tick
);

    state_t             state_r;
    logic [ADDR_W-1:0]  cur_r;
    logic [ADDR_W-1:0]  last_r;
`ifdef VGA_REGION_WRAP_EN
    logic [ADDR_W-1:0]  base_r;
`endif
    logic               load_s;
    logic               advance_s;
    logic [PIXEL_W-1:0] colour_s;
    logic               last_lane_s;

    // Abort wins over the handshake, so a word offered alongside abort is never taken.
    always_comb begin
        load_s    = (state_r == ST_ACCEPT) && in_valid && in_ready && !abort;
        advance_s = (state_r == ST_EMIT) && !abort;
    end

    vga_word_unpacker #(
        .DATA_W  (DATA_W),
        .PIXEL_W (PIXEL_W)
    ) u_unpacker (
        .clk       (CLOCK_50),
        .resetn    (resetn),
        .load      (load_s),
        .advance   (advance_s),
        .in_data   (in_data),
        .colour    (colour_s),
        .last_lane (last_lane_s)
    );

    // Region FSM; plot/done strobes are registered from the state they belong to.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            cur_r      <= '0;
            last_r     <= '0;
`ifdef VGA_REGION_WRAP_EN
            base_r     <= '0;
`endif
            in_ready   <= 1'b0;
            pix_plot   <= 1'b0;
            pix_addr   <= '0;
            pix_colour <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wrap_tick  <= 1'b0;
        end else begin
            pix_plot  <= 1'b0;
            done      <= 1'b0;
            wrap_tick <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && (cfg_last >= cfg_base)) begin
`ifdef VGA_REGION_WRAP_EN
                        base_r   <= cfg_base;
`endif
                        last_r   <= cfg_last;
                        cur_r    <= cfg_base;
                        state_r  <= ST_ACCEPT;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end else if (start) begin
                        state_r  <= ST_DONE;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_ACCEPT: begin
                    if (abort) begin
                        state_r  <= ST_IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end else if (load_s) begin
                        state_r  <= ST_EMIT;
                        in_ready <= 1'b0;
                    end else begin
                        state_r  <= ST_ACCEPT;
                    end
                end
                ST_EMIT: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        pix_plot   <= 1'b1;
                        pix_addr   <= cur_r;
                        pix_colour <= colour_s;
                        if (cur_r == last_r) begin
`ifdef VGA_REGION_WRAP_EN
                            wrap_tick <= 1'b1;
                            cur_r     <= base_r;
                            if (last_lane_s) begin
                                state_r  <= ST_ACCEPT;
                                in_ready <= 1'b1;
                            end else begin
                                state_r  <= ST_EMIT;
                            end
`else
                            state_r <= ST_DONE;
                            busy    <= 1'b0;
`endif
                        end else begin
                            cur_r <= cur_r + ADDR_W'(1);
                            if (last_lane_s) begin
                                state_r  <= ST_ACCEPT;
                                in_ready <= 1'b1;
                            end else begin
                                state_r  <= ST_EMIT;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_region_writer.sv
// Directed bench for vga_region_writer: table of whole-region runs plus reset/abort sequences.
module tb_vga_region_writer;

    logic        CLOCK_50 = 1'b0;
    logic        resetn;
    logic        start;
    logic        abort;
    logic [16:0] cfg_base;
    logic [16:0] cfg_last;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        pix_plot;
    logic [16:0] pix_addr;
    logic [7:0]  pix_colour;
    logic        busy;
    logic        done;
    logic        wrap_tick;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [16:0] base;
        logic [16:0] last;
        logic [63:0] words;
        int          nwords;
        int          gap;
        int          nplots;
        int          exp_words;
        logic [63:0] cols;
    } vec_t;

    vec_t tbl[4];

    vga_region_writer dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .start      (start),
        .abort      (abort),
        .cfg_base   (cfg_base),
        .cfg_last   (cfg_last),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .pix_plot   (pix_plot),
        .pix_addr   (pix_addr),
        .pix_colour (pix_colour),
        .busy       (busy),
        .done       (done),
        .wrap_tick  (wrap_tick)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLOCK_50);
    endtask

    task automatic run_region(input int idx);
        vec_t v;
        int wi, gap_cnt, nplot, first_c, last_c, done_c, ndone;
        logic gap_flag;
        v = tbl[idx];
        wi = 0; gap_cnt = 0; nplot = 0; first_c = -1; last_c = -1; done_c = -1; ndone = 0;
        gap_flag = 1'b0;
        cfg_base = v.base;
        cfg_last = v.last;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                if (gap_flag) begin
                    chk($sformatf("r%0d_gap_idle", idx), {62'd0, pix_plot, in_ready}, 64'd1);
                    gap_flag = 1'b0;
                end
                if (pix_plot) begin
                    if (nplot < v.nplots) begin
                        chk($sformatf("r%0d_addr%0d", idx, nplot), 64'(pix_addr), 64'(v.base + 17'(nplot)));
                        chk($sformatf("r%0d_col%0d", idx, nplot), 64'(pix_colour), 64'(v.cols[nplot*8 +: 8]));
                    end
                    if (first_c < 0) first_c = c;
                    last_c = c;
                    nplot++;
                end
                if (done) begin
                    ndone++;
                    done_c = c;
                end
                if (wrap_tick) chk($sformatf("r%0d_wrap", idx), 64'd1, 64'd0);
            end
            start = (c == 0);
            if (gap_cnt > 0 && in_ready) begin
                in_valid = 1'b0;
                gap_cnt--;
                gap_flag = 1'b1;
            end else if (wi < v.nwords) begin
                in_valid = 1'b1;
                in_data  = v.words[wi*32 +: 32];
                if (in_ready) begin
                    wi++;
                    gap_cnt = v.gap;
                end
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        chk($sformatf("r%0d_nplots", idx), 64'(nplot), 64'(v.nplots));
        chk($sformatf("r%0d_ndone", idx), 64'(ndone), 64'd1);
        chk($sformatf("r%0d_done_cycle", idx), 64'(done_c), 64'((v.nplots > 0) ? last_c + 1 : 2));
        if (v.nplots > 0) chk($sformatf("r%0d_first_plot", idx), 64'(first_c), 64'd3);
        chk($sformatf("r%0d_words_taken", idx), 64'(wi), 64'(v.exp_words));
        chk($sformatf("r%0d_idle_after", idx), {62'd0, busy, in_ready}, 64'd0);
    endtask

    initial begin
        tbl[0] = '{17'h057E4, 17'h057EB, 64'h44332211_DDCCBBAA, 2, 0, 8, 2, 64'h44332211_DDCCBBAA};
        tbl[1] = '{17'h00100, 17'h00101, 64'h55667788_44332211, 2, 0, 2, 1, 64'h00000000_00002211};
        tbl[2] = '{17'h00005, 17'h00004, 64'h0, 0, 0, 0, 0, 64'h0};
        tbl[3] = '{17'h00200, 17'h00207, 64'h0FEDCBA9_87654321, 2, 3, 8, 2, 64'h0FEDCBA9_87654321};

        resetn = 1'b0; start = 1'b0; abort = 1'b0; cfg_base = '0; cfg_last = '0;
        in_valid = 1'b0; in_data = '0;
        tick(); tick();
        chk("reset_outputs", {in_ready, pix_plot, pix_addr, pix_colour, busy, done, wrap_tick}, 64'd0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_region(i);

        // Reset in the middle of EMIT.
        cfg_base = 17'h057E4; cfg_last = 17'h057EB; start = 1'b1;
        tick(); start = 1'b0;
        chk("rst_seq_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_data = 32'hDDCCBBAA;
        tick(); in_valid = 1'b0;
        tick();
        chk("rst_seq_plot", {45'd0, pix_plot, pix_addr}, {45'd0, 1'b1, 17'h057E4});
        resetn = 1'b0;
        tick(); tick();
        chk("rst_mid_outputs", {in_ready, pix_plot, pix_addr, pix_colour, busy, done, wrap_tick}, 64'd0);
        resetn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rst_mid_quiet", {62'd0, done, pix_plot}, 64'd0);
        end
        run_region(0);

        // Abort while lane 2 of the first word is current.
        cfg_base = 17'h00040; cfg_last = 17'h0004F; start = 1'b1;
        tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'hDDCCBBAA;
        tick(); in_valid = 1'b0;
        tick();
        chk("abort_l0", {47'd0, pix_plot, pix_colour, 8'(pix_addr)}, {47'd0, 1'b1, 8'hAA, 8'h40});
        tick();
        chk("abort_l1", {55'd0, pix_plot, pix_colour}, {55'd0, 1'b1, 8'hBB});
        abort = 1'b1;
        tick(); abort = 1'b0;
        chk("abort_stop", {62'd0, pix_plot, busy}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("abort_quiet", {61'd0, done, pix_plot, busy}, 64'd0);
        end

        // Abort coincident with an offered word in ACCEPT.
        cfg_base = 17'h00080; cfg_last = 17'h00087; start = 1'b1;
        tick(); start = 1'b0;
        chk("abort_acc_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_data = 32'h12345678; abort = 1'b1;
        tick(); abort = 1'b0;
        chk("abort_acc_state", {62'd0, in_ready, busy}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("abort_acc_noplot", {62'd0, pix_plot, done}, 64'd0);
        end
        in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
